// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        START,
        DATA,
        STOP
    } state_e;

    localparam int unsigned FRAME_BITS = 10;
    localparam logic        TX_IDLE    = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick is high on the last clock of every CLKS_PER_BIT period.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from an upstream FIFO one at a time and sends each as an 8N1 frame on tx.
module fifo_uart_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    import uart_pkg::*;

    localparam int unsigned   BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              tick;
    logic              baud_clr;

    // Hold the bit timer at zero until the frame starts so START gets a full period.
    assign baud_clr = (state_q == IDLE) || (state_q == READ) || (state_q == LOAD);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= TX_IDLE;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        case (state_q)
            IDLE: begin
                if (en && !fifo_empty) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo_dout;
                tx_d    = 1'b0;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_d    = TX_IDLE;
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_rd    = (state_q == READ);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == STOP) && tick;
    assign tx         = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue-based FIFO, per-cycle frame model, serial decoder.
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned DW  = 8;

    logic          clk = 1'b0;
    logic          rst, en, fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd, tx, busy, frame_done;

    fifo_uart_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic rd;
        logic busy;
        logic done;
    } exp_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         busy_total = 0;
    logic [7:0] push_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] dec_q[$];
    int         rd_cyc[$];
    int         done_cyc[$];
    int         fall_cyc[$];
    logic [9:0] last_frame = '0;
    exp_t       exp_q[$];
    exp_t       cur;
    logic       model_valid = 1'b0;
    int         r0, d0, f0, k0, b0;
    logic [7:0] rnd_exp[$];

    function automatic exp_t mk(input logic t, input logic r, input logic b, input logic d);
        exp_t e;
        e.tx = t; e.rd = r; e.busy = b; e.done = d;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        push_q.push_back(b);
    endtask

    task automatic snap();
        r0 = rd_cyc.size(); d0 = done_cyc.size(); f0 = fall_cyc.size();
        k0 = dec_q.size();  b0 = busy_total;
    endtask

    // Upstream FIFO: pops on fifo_rd, data appears after that edge.
    task automatic fifo_proc();
        int         seen;
        logic [7:0] b;
        seen = 0;
        forever begin
            @(posedge clk);
            if (fifo_rd && fifo_q.size() > 0) begin
                b = fifo_q.pop_front();
                fifo_dout <= b;
            end
            while (seen < push_q.size()) begin
                fifo_q.push_back(push_q[seen]);
                seen++;
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
    endtask

    // A frame is: READ, LOAD, then 10 serial bits of CPB cycles each, done on the last.
    task automatic build(input logic [7:0] d);
        logic v;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
        for (int b = 0; b < 10; b++) begin
            v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
            for (int c = 0; c < int'(CPB); c++) begin
                exp_q.push_back(mk(v, 1'b0, 1'b1, (b == 9) && (c == int'(CPB) - 1)));
            end
        end
    endtask

    task automatic model_proc();
        logic prev_idle;
        prev_idle = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                cur = mk(1'b1, 1'b0, 1'b0, 1'b0);
            end else if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
            end else if (prev_idle && en && !fifo_empty) begin
                build(fifo_q[0]);
                cur = exp_q.pop_front();
            end else begin
                cur = mk(1'b1, 1'b0, 1'b0, 1'b0);
            end
            prev_idle   = !cur.busy;
            model_valid = 1'b1;
        end
    endtask

    task automatic mon_proc();
        forever begin
            @(negedge clk);
            if (model_valid) begin
                chk("outputs{tx,rd,busy,done}", {tx, fifo_rd, busy, frame_done}, cur);
            end
            if (fifo_rd === 1'b1) begin
                rd_cyc.push_back(cyc);
                chk("rd_while_empty", fifo_empty, 0);
            end
            if (frame_done === 1'b1) done_cyc.push_back(cyc);
            if (busy === 1'b1) busy_total++;
        end
    endtask

    // Samples each serial bit mid-period, starting from the falling edge of the start bit.
    task automatic dec_proc();
        logic       prev_tx;
        logic [9:0] bits;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (prev_tx === 1'b1 && tx === 1'b0) begin
                fall_cyc.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                bits[0] = tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (CPB) @(negedge clk);
                    bits[i] = tx;
                end
                dec_q.push_back(bits[8:1]);
                last_frame = bits;
            end
            prev_tx = tx;
        end
    endtask

    task automatic wait_rd(input int bound);
        int got;
        got = 0;
        for (int i = 0; i < bound && got == 0; i++) begin
            @(negedge clk);
            if (fifo_rd === 1'b1) got = 1;
        end
        chk("wait_rd_timeout", got, 1);
    endtask

    task automatic wait_drain(input string name, input int bound, input logic need_empty);
        int q;
        q = 0;
        for (int i = 0; i < bound && !(q >= 4 && (!need_empty || fifo_empty)); i++) begin
            @(negedge clk);
            q = (busy === 1'b0) ? q + 1 : 0;
        end
        chk(name, int'(q >= 4 && (!need_empty || fifo_empty)), 1);
    endtask

    initial begin
        logic [7:0] v;
        rst = 1'b1; en = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
        fork
            fifo_proc();
            model_proc();
            mon_proc();
            dec_proc();
            begin
                #1_000_000;
                $display("FAIL watchdog: got running, expected finished (cycle %0d)", cyc);
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_rd", fifo_rd, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", frame_done, 0);
        rst = 1'b0;

        // Single A5 frame with literal timing.
        snap();
        push(8'hA5); en = 1'b1;
        wait_drain("a5_timeout", 200, 1'b1);
        chk("a5_rd_count", rd_cyc.size() - r0, 1);
        chk("a5_done_count", done_cyc.size() - d0, 1);
        chk("a5_busy_cycles", busy_total - b0, 42);
        if (rd_cyc.size() > r0 && done_cyc.size() > d0)
            chk("a5_rd_to_done", done_cyc[d0] - rd_cyc[r0], 41);
        if (rd_cyc.size() > r0 && fall_cyc.size() > f0)
            chk("a5_rd_to_start", fall_cyc[f0] - rd_cyc[r0], 2);
        if (dec_q.size() > k0) chk("a5_byte", dec_q[k0], 8'hA5);
        chk("a5_frame_bits", last_frame, 10'b11_0100_1010);

        // Empty FIFO with en high.
        snap();
        repeat (100) @(negedge clk);
        chk("empty_rd_count", rd_cyc.size() - r0, 0);
        chk("empty_busy_cycles", busy_total - b0, 0);
        chk("empty_tx", tx, 1);

        // Two queued bytes back to back.
        en = 1'b0; snap();
        push(8'h01); push(8'h80); en = 1'b1;
        wait_drain("pair_timeout", 300, 1'b1);
        chk("pair_rd_count", rd_cyc.size() - r0, 2);
        if (rd_cyc.size() > r0 + 1) chk("pair_rd_gap", rd_cyc[r0+1] - rd_cyc[r0], 43);
        chk("pair_dec_count", dec_q.size() - k0, 2);
        if (dec_q.size() > k0 + 1) begin
            chk("pair_byte0", dec_q[k0], 8'h01);
            chk("pair_byte1", dec_q[k0+1], 8'h80);
        end

        // Reset during DATA bit 3 of FF.
        snap();
        push(8'hFF);
        wait_rd(20);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_drain("midrst_timeout", 100, 1'b1);
        repeat (12 * CPB) @(negedge clk);
        chk("midrst_rd_count", rd_cyc.size() - r0, 1);
        chk("midrst_done_count", done_cyc.size() - d0, 0);

        // en low holds off reads; en dropped during START lets the frame finish.
        en = 1'b0; snap();
        push(8'h3C); push(8'h55);
        repeat (50) @(negedge clk);
        chk("en_low_rd_count", rd_cyc.size() - r0, 0);
        en = 1'b1;
        wait_rd(20);
        repeat (3) @(negedge clk);
        en = 1'b0;
        wait_drain("en_drop_timeout", 200, 1'b0);
        repeat (20) @(negedge clk);
        chk("en_drop_rd_count", rd_cyc.size() - r0, 1);
        chk("en_drop_dec_count", dec_q.size() - k0, 1);
        if (dec_q.size() > k0) chk("en_drop_byte", dec_q[k0], 8'h3C);
        chk("en_drop_fifo_left", fifo_empty, 0);
        en = 1'b1;
        wait_drain("en_resume_timeout", 200, 1'b1);
        if (dec_q.size() > k0 + 1) chk("en_resume_byte", dec_q[k0+1], 8'h55);

        // Sixteen small random bytes through the FIFO.
        en = 1'b0; snap();
        rnd_exp.delete();
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom_range(0, 7));
            rnd_exp.push_back(v);
            push(v);
        end
        en = 1'b1;
        wait_drain("int_timeout", 16 * 60, 1'b1);
        chk("int_rd_count", rd_cyc.size() - r0, 16);
        chk("int_dec_count", dec_q.size() - k0, 16);
        for (int i = 0; i < 16; i++) begin
            if (dec_q.size() > k0 + i) chk("int_byte", dec_q[k0+i], rnd_exp[i]);
        end
        chk("int_fifo_empty", fifo_empty, 1);
        snap();
        repeat (100) @(negedge clk);
        chk("int_rd_after", rd_cyc.size() - r0, 0);

        // Random pushes with en toggling.
        snap();
        rnd_exp.delete();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) begin
                v = 8'($urandom);
                rnd_exp.push_back(v);
                push(v);
            end
            en = ($urandom_range(0, 7) != 0);
        end
        en = 1'b1;
        wait_drain("rand_timeout", 20000, 1'b1);
        chk("rand_dec_count", dec_q.size() - k0, rnd_exp.size());
        for (int i = 0; i < rnd_exp.size(); i++) begin
            if (dec_q.size() > k0 + i) chk("rand_byte", dec_q[k0+i], rnd_exp[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
